// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transceiver.
// Optional feature macro: UART_PARITY_EN (even parity bit after data bit 7).
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_IDX_W  = 3;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_CNT_W = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator for the receiver; parked at zero while disabled
// so the first tick of a frame is phase-aligned to the detected start edge.
module uart_baud_gen #(
    parameter int unsigned DIV = 27
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Divide the clock down to a one-cycle tick every DIV cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_W'(DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart.sv
// 8N1 UART transceiver: independent TX and RX sharing one clock domain.
// Optional feature macro: UART_PARITY_EN adds an even parity bit (11-bit frame)
// and the parity_err output.
module uart #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    import uart_pkg::*;

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned RX_TICK_DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned CPB_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // ---------------- transmitter ----------------
    tx_state_e              r_tx_state, w_tx_state_nxt;
    logic [CPB_W-1:0]       r_tx_cnt, w_tx_cnt_nxt;
    logic [BIT_IDX_W-1:0]   r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0]   r_tx_data, w_tx_data_nxt;
    logic                   r_tx, w_tx_nxt;
    logic                   r_tx_busy, w_tx_busy_nxt;
    logic                   w_tx_bit_done;

    assign w_tx_bit_done = (r_tx_cnt == CPB_W'(CLKS_PER_BIT - 1));

    // TX state and line register; the bit timer restarts on every accepted write.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_data  <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
        end
    end

    // TX next state: the next line level is computed one cycle ahead of each bit.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CPB_W'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_data_nxt  = r_tx_data;
        w_tx_nxt       = r_tx;
        w_tx_busy_nxt  = r_tx_busy;
        if (r_tx_state == TX_IDLE) begin
            w_tx_cnt_nxt = '0;
            if (wr_en) begin
                w_tx_state_nxt = TX_START;
                w_tx_data_nxt  = din;
                w_tx_bit_nxt   = '0;
                w_tx_nxt       = 1'b0;
                w_tx_busy_nxt  = 1'b1;
            end
        end else if (w_tx_bit_done) begin
            w_tx_cnt_nxt = '0;
            case (r_tx_state)
                TX_START: begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_nxt       = r_tx_data[0];
                end
                TX_DATA: begin
                    if (r_tx_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        w_tx_state_nxt = TX_PARITY;
                        w_tx_nxt       = ^r_tx_data;
`else
                        w_tx_state_nxt = TX_STOP;
                        w_tx_nxt       = 1'b1;
`endif
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + BIT_IDX_W'(1);
                        w_tx_nxt     = r_tx_data[r_tx_bit + BIT_IDX_W'(1)];
                    end
                end
                TX_PARITY: begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_nxt       = 1'b1;
                end
                default: begin
                    w_tx_state_nxt = TX_IDLE;
                    w_tx_nxt       = 1'b1;
                    w_tx_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;

    // ---------------- receiver ----------------
    logic                   r_rx_meta, r_rx_sync;
    rx_state_e              r_rx_state, w_rx_state_nxt;
    logic [TICK_CNT_W-1:0]  r_rx_tick_cnt, w_rx_tick_cnt_nxt;
    logic [BIT_IDX_W-1:0]   r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic [DATA_BITS-1:0]   r_dout, w_dout_nxt;
    logic                   r_rdy, w_rdy_nxt;
    logic                   w_rx_tick, w_rx_en, w_rx_good, w_rx_mid, w_rx_end;
`ifdef UART_PARITY_EN
    logic                   r_rx_par, w_rx_par_nxt;
    logic                   r_parity_err, w_parity_err_nxt;
`endif

    assign w_rx_en  = (r_rx_state != RX_IDLE);
    assign w_rx_mid = w_rx_tick && (r_rx_tick_cnt == TICK_CNT_W'(OVERSAMPLE / 2 - 1));
    assign w_rx_end = w_rx_tick && (r_rx_tick_cnt == TICK_CNT_W'(OVERSAMPLE - 1));

    uart_baud_gen #(
        .DIV (RX_TICK_DIV)
    ) u_baud_gen (
        .i_clk  (clk_50m),
        .i_rst  (rst),
        .i_en   (w_rx_en),
        .o_tick (w_rx_tick)
    );

    // Two-stage synchroniser for the asynchronous serial input.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX state, sample counters and host-side result registers.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_rx_state    <= RX_IDLE;
            r_rx_tick_cnt <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_dout        <= '0;
            r_rdy         <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par      <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_rx_state    <= w_rx_state_nxt;
            r_rx_tick_cnt <= w_rx_tick_cnt_nxt;
            r_rx_bit      <= w_rx_bit_nxt;
            r_rx_shift    <= w_rx_shift_nxt;
            r_dout        <= w_dout_nxt;
            r_rdy         <= w_rdy_nxt;
`ifdef UART_PARITY_EN
            r_rx_par      <= w_rx_par_nxt;
            r_parity_err  <= w_parity_err_nxt;
`endif
        end
    end

    // RX next state: mid-bit sampling on the 16x tick, start bit re-checked to reject glitches.
    always_comb begin
        w_rx_state_nxt    = r_rx_state;
        w_rx_tick_cnt_nxt = r_rx_tick_cnt;
        w_rx_bit_nxt      = r_rx_bit;
        w_rx_shift_nxt    = r_rx_shift;
        w_rx_good         = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_nxt      = r_rx_par;
`endif
        if (w_rx_tick) begin
            w_rx_tick_cnt_nxt = r_rx_tick_cnt + TICK_CNT_W'(1);
        end
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_tick_cnt_nxt = '0;
                w_rx_bit_nxt      = '0;
                if (!r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_mid) begin
                    w_rx_tick_cnt_nxt = '0;
                    if (r_rx_sync) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_end) begin
                    w_rx_tick_cnt_nxt = '0;
                    w_rx_shift_nxt    = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        w_rx_state_nxt = RX_PARITY;
`else
                        w_rx_state_nxt = RX_STOP;
`endif
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + BIT_IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (w_rx_end) begin
                    w_rx_tick_cnt_nxt = '0;
                    w_rx_state_nxt    = RX_STOP;
`ifdef UART_PARITY_EN
                    w_rx_par_nxt      = r_rx_sync;
`endif
                end
            end
            default: begin
                if (w_rx_end) begin
                    w_rx_tick_cnt_nxt = '0;
                    w_rx_state_nxt    = RX_IDLE;
                    w_rx_good         = r_rx_sync;
                end
            end
        endcase
    end

    // Host flags: a good stop bit sets rdy and wins over a simultaneous clear.
    always_comb begin
        w_dout_nxt = w_rx_good ? r_rx_shift : r_dout;
        w_rdy_nxt  = w_rx_good | (r_rdy & ~rdy_clr);
`ifdef UART_PARITY_EN
        w_parity_err_nxt = w_rx_good ? (r_rx_par ^ (^r_rx_shift)) : (r_parity_err & ~rdy_clr);
`endif
    end

    assign rdy  = r_rdy;
    assign dout = r_dout;
`ifdef UART_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for uart; runs with scaled clock/baud (32 clocks per bit,
// 16x tick every 2 clocks) to keep the loopback sweep short. Honours UART_PARITY_EN.
module tb_uart;

    localparam int CPB      = 32;
    localparam int TICK_DIV = 2;
`ifdef UART_PARITY_EN
    localparam int FRAME    = 11;
`else
    localparam int FRAME    = 10;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       rdy;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       loop_sel;
    logic       rx_drv;
    logic       seen_rdy;
`ifdef UART_PARITY_EN
    logic       parity_err;
    logic       inject_par_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    assign rx = loop_sel ? tx : rx_drv;

    uart #(
        .CLK_HZ (3_200_000),
        .BAUD   (100_000)
    ) dut (
        .clk_50m (clk),
        .rst     (rst),
        .din     (din),
        .wr_en   (wr_en),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx),
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #(200000 * 20);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle write strobe; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        din   = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Count clock edges until tx_busy drops (bounded).
    task automatic measure_busy(output int cycles);
        cycles = 0;
        while (tx_busy && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic clear_rdy();
        @(negedge clk);
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
    endtask

    // Bit-bang one frame on rx_drv, followed by two idle bit times.
    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ inject_par_err;
        repeat (CPB) @(negedge clk);
`endif
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        din      = 8'h00;
        wr_en    = 1'b0;
        rdy_clr  = 1'b0;
        loop_sel = 1'b1;
        rx_drv   = 1'b1;
        seen_rdy = 1'b0;
`ifdef UART_PARITY_EN
        inject_par_err = 1'b0;
`endif
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_tx", 32'(tx), 1);
        check_eq("rst_busy", 32'(tx_busy), 0);
        check_eq("rst_rdy", 32'(rdy), 0);
        check_eq("rst_dout", 32'(dout), 0);

        // Single loopback byte with exact frame length.
        send_byte(8'h99);
        check_eq("first_busy", 32'(tx_busy), 1);
        check_eq("first_tx_start", 32'(tx), 0);
        measure_busy(cyc);
        check_eq("first_len", 32'(cyc), FRAME * CPB);
        check_eq("first_rdy", 32'(rdy), 1);
        check_eq("first_dout", 32'(dout), 8'h99);
`ifdef UART_PARITY_EN
        check_eq("first_par_err", 32'(parity_err), 0);
`endif
        clear_rdy();
        check_eq("first_rdy_clr", 32'(rdy), 0);

        // Back-to-back frames: write accepted in the cycle tx_busy falls; second byte overwrites dout.
        send_byte(8'hA5);
        measure_busy(cyc);
        check_eq("b2b_dout1", 32'(dout), 8'hA5);
        din   = 8'h3C;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check_eq("b2b_accept", 32'(tx_busy), 1);
        measure_busy(cyc);
        check_eq("b2b_len", 32'(cyc), FRAME * CPB);
        check_eq("b2b_rdy", 32'(rdy), 1);
        check_eq("b2b_dout2", 32'(dout), 8'h3C);
        clear_rdy();

        // Write and din change while busy are ignored.
        send_byte(8'h81);
        repeat (50) @(negedge clk);
        din   = 8'h55;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        din   = 8'hAA;
        measure_busy(cyc);
        check_eq("ign_len", 32'(cyc), FRAME * CPB - 50);
        check_eq("ign_dout", 32'(dout), 8'h81);
        clear_rdy();
        repeat (2 * FRAME * CPB) @(negedge clk);
        check_eq("ign_no_second", 32'(rdy), 0);
        check_eq("ign_line_idle", 32'(tx), 1);

        // Loopback sweep.
        for (int v = 8'h99; v <= 8'hFF; v++) begin
            send_byte(8'(v));
            measure_busy(cyc);
            check_eq("sweep_rdy", 32'(rdy), 1);
            check_eq("sweep_dout", 32'(dout), 32'(v));
            clear_rdy();
        end
        check_eq("sweep_last", 32'(dout), 8'hFF);

        // Start-bit glitch of 4 ticks is rejected; a following frame is received.
        @(negedge clk);
        loop_sel = 1'b0;
        rx_drv   = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check_eq("glitch_no_rdy", 32'(rdy), 0);
        send_rx(8'h5A, 1'b1);
        check_eq("glitch_then_rdy", 32'(rdy), 1);
        check_eq("glitch_then_dout", 32'(dout), 8'h5A);
        clear_rdy();

        // Framing error: byte dropped, flags and dout untouched.
        send_rx(8'hC3, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check_eq("frm_err_rdy", 32'(rdy), 0);
        check_eq("frm_err_dout", 32'(dout), 8'h5A);

        // rdy_clr held through reception: set wins for one cycle, then clear takes effect.
        @(negedge clk);
        rdy_clr  = 1'b1;
        seen_rdy = 1'b0;
        fork
            send_rx(8'hE7, 1'b1);
            begin
                repeat ((FRAME + 2) * CPB) begin
                    @(posedge clk);
                    #1;
                    if (rdy) seen_rdy = 1'b1;
                end
            end
        join
        @(negedge clk);
        rdy_clr = 1'b0;
        check_eq("setwin_seen", 32'(seen_rdy), 1);
        check_eq("setwin_dout", 32'(dout), 8'hE7);
        check_eq("setwin_cleared", 32'(rdy), 0);

`ifdef UART_PARITY_EN
        // Flipped parity bit: byte still delivered with parity_err.
        inject_par_err = 1'b1;
        send_rx(8'h6B, 1'b1);
        inject_par_err = 1'b0;
        check_eq("par_rdy", 32'(rdy), 1);
        check_eq("par_err", 32'(parity_err), 1);
        check_eq("par_dout", 32'(dout), 8'h6B);
        clear_rdy();
        check_eq("par_err_clr", 32'(parity_err), 0);
`endif

        // Reset mid-TX frame.
        @(negedge clk);
        loop_sel = 1'b1;
        send_byte(8'hF0);
        repeat (100) @(negedge clk);
        check_eq("midrst_pre_busy", 32'(tx_busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_tx", 32'(tx), 1);
        check_eq("midrst_busy", 32'(tx_busy), 0);
        check_eq("midrst_dout", 32'(dout), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME * CPB) @(negedge clk);
        check_eq("midrst_no_rdy", 32'(rdy), 0);
        check_eq("midrst_idle", 32'(tx), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
